// File: rtl/alu_opcodes_pkg.sv
// Shared ALU opcode encoding, register-file sizing and the operand-stage output entry.
package alu_opcodes_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
    } alu_req_t;

endpackage

// File: rtl/alu_operand_stage_rf_2r1w.sv
// Architectural register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, asynchronous clear.
module rf_2r1w #(
    parameter int unsigned DATA_W = alu_opcodes_pkg::DATA_W,
    parameter int unsigned ADDR_W = alu_opcodes_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we_i && (wa_i != '0)) begin
            mem_d[wa_i] = wd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: register read with same-cycle write bypass,
// immediate select, and a one-entry valid/ready output register.
module alu_operand_stage #(
    parameter int unsigned DATA_W = alu_opcodes_pkg::DATA_W,
    parameter int unsigned ADDR_W = alu_opcodes_pkg::ADDR_W,
    parameter int unsigned OP_W   = alu_opcodes_pkg::OP_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic              use_imm_i,
    input  logic [OP_W-1:0]   alu_op_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [OP_W-1:0]   alu_op_o,
    output logic [ADDR_W-1:0] rd_o
);

    logic [DATA_W-1:0] rf_rd1, rf_rd2;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              accept;

    alu_opcodes_pkg::alu_req_t req_q, req_d;
    logic                      valid_q, valid_d;

    rf_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (we_i),
        .wa_i   (wa_i),
        .wd_i   (wd_i),
        .ra1_i  (ra1_i),
        .ra2_i  (ra2_i),
        .rd1_o  (rf_rd1),
        .rd2_o  (rf_rd2)
    );

    // x0 check wins over bypass so a write to x0 can never leak into a read.
    always_comb begin
        rdata1 = rf_rd1;
        if (ra1_i == '0) begin
            rdata1 = '0;
        end else if (we_i && (wa_i == ra1_i)) begin
            rdata1 = wd_i;
        end
        rdata2 = rf_rd2;
        if (ra2_i == '0) begin
            rdata2 = '0;
        end else if (we_i && (wa_i == ra2_i)) begin
            rdata2 = wd_i;
        end
    end

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        req_d   = req_q;
        valid_d = valid_q && !out_ready_i;
        if (accept) begin
            req_d.a  = rdata1;
            req_d.b  = use_imm_i ? imm_i : rdata2;
            req_d.op = alu_op_i;
            req_d.rd = rd_i;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid_o = valid_q;
    assign a_o         = req_q.a;
    assign b_o         = req_q.b;
    assign alu_op_o    = req_q.op;
    assign rd_o        = req_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios then randomized traffic
// against a register-array / queue reference model.
module tb_alu_operand_stage;
    import alu_opcodes_pkg::*;

    logic              clk_i       = 1'b0;
    logic              rst_ni      = 1'b0;
    logic              in_valid_i  = 1'b0;
    logic              in_ready_o;
    logic [ADDR_W-1:0] ra1_i       = '0;
    logic [ADDR_W-1:0] ra2_i       = '0;
    logic [DATA_W-1:0] imm_i       = '0;
    logic              use_imm_i   = 1'b0;
    logic [OP_W-1:0]   alu_op_i    = '0;
    logic [ADDR_W-1:0] rd_i        = '0;
    logic              we_i        = 1'b0;
    logic [ADDR_W-1:0] wa_i        = '0;
    logic [DATA_W-1:0] wd_i        = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b1;
    logic [DATA_W-1:0] a_o;
    logic [DATA_W-1:0] b_o;
    logic [OP_W-1:0]   alu_op_o;
    logic [ADDR_W-1:0] rd_o;

    alu_operand_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .ra1_i       (ra1_i),
        .ra2_i       (ra2_i),
        .imm_i       (imm_i),
        .use_imm_i   (use_imm_i),
        .alu_op_i    (alu_op_i),
        .rd_i        (rd_i),
        .we_i        (we_i),
        .wa_i        (wa_i),
        .wd_i        (wd_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .a_o         (a_o),
        .b_o         (b_o),
        .alu_op_o    (alu_op_o),
        .rd_o        (rd_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [DATA_W-1:0] m_regs [32];
    alu_req_t          m_ent;
    bit                m_valid;
    alu_req_t          sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] ra);
        if (ra == 0) return '0;
        if (we_i && wa_i == ra) return wd_i;
        return m_regs[ra];
    endfunction

    task automatic m_reset();
        m_valid = 0;
        m_ent   = '0;
        foreach (m_regs[i]) m_regs[i] = '0;
        sb.delete();
    endtask

    // One clock: inputs already applied at the falling edge; model advances with the edge.
    task automatic cyc();
        alu_req_t e, f;
        bit acc;
        #1;
        chk("in_ready", 32'(in_ready_o), 32'(!m_valid || out_ready_i));
        if (m_valid && out_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow observed=emit expected=no_entry");
            end else begin
                f = sb.pop_front();
                chk("emit_a", a_o, f.a);
                chk("emit_b", b_o, f.b);
            end
        end
        acc = in_valid_i && (!m_valid || out_ready_i);
        if (acc) begin
            e.a  = m_read(ra1_i);
            e.b  = use_imm_i ? imm_i : m_read(ra2_i);
            e.op = alu_op_i;
            e.rd = rd_i;
            sb.push_back(e);
            m_ent   = e;
            m_valid = 1;
        end else if (out_ready_i) begin
            m_valid = 0;
        end
        if (we_i && wa_i != 0) m_regs[wa_i] = wd_i;
        @(posedge clk_i);
        #1;
        chk("out_valid", 32'(out_valid_o), 32'(m_valid));
        chk("a_o", a_o, m_ent.a);
        chk("b_o", b_o, m_ent.b);
        chk("alu_op_o", 32'(alu_op_o), 32'(m_ent.op));
        chk("rd_o", 32'(rd_o), 32'(m_ent.rd));
        @(negedge clk_i);
    endtask

    task automatic idle();
        in_valid_i  = 0;
        we_i        = 0;
        use_imm_i   = 0;
        out_ready_i = 1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                         input logic ui, input logic [DATA_W-1:0] imm,
                         input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rd);
        in_valid_i = 1;
        ra1_i      = r1;
        ra2_i      = r2;
        use_imm_i  = ui;
        imm_i      = imm;
        alu_op_i   = op;
        rd_i       = rd;
    endtask

    logic [DATA_W-1:0] held_a;

    initial begin
        m_reset();
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_a", a_o, 32'd0);
        chk("rst_b", b_o, 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        rst_ni = 1;

        // read after reset
        issue(5'd3, 5'd4, 0, '0, ALU_ADD, 5'd1);
        cyc();
        chk("rr_valid", 32'(out_valid_o), 32'd1);
        chk("rr_a", a_o, 32'd0);
        chk("rr_b", b_o, 32'd0);

        // write then read
        idle();
        we_i = 1; wa_i = 5'd5; wd_i = 32'h1234_5678;
        cyc();
        we_i = 0;
        issue(5'd5, 5'd0, 0, '0, ALU_ADD, 5'd7);
        cyc();
        chk("wr_a", a_o, 32'h1234_5678);
        chk("wr_b", b_o, 32'd0);
        chk("wr_op", 32'(alu_op_o), 32'(ALU_ADD));
        chk("wr_rd", 32'(rd_o), 32'd7);

        // same-cycle bypass
        we_i = 1; wa_i = 5'd9; wd_i = 32'hDEAD_BEEF;
        issue(5'd9, 5'd9, 0, '0, ALU_OR, 5'd3);
        cyc();
        chk("byp_a", a_o, 32'hDEAD_BEEF);
        chk("byp_b", b_o, 32'hDEAD_BEEF);

        // x0 write ignored, also during same-cycle read
        we_i = 1; wa_i = 5'd0; wd_i = 32'hFFFF_FFFF;
        issue(5'd0, 5'd0, 0, '0, ALU_ADD, 5'd0);
        cyc();
        chk("x0_byp_a", a_o, 32'd0);
        we_i = 0;
        cyc();
        chk("x0_a", a_o, 32'd0);

        // immediate select
        idle();
        we_i = 1; wa_i = 5'd2; wd_i = 32'd10;
        cyc();
        we_i = 0;
        issue(5'd2, 5'd9, 1, 32'hFFFF_FFF6, ALU_SUB, 5'd4);
        cyc();
        chk("imm_a", a_o, 32'd10);
        chk("imm_b", b_o, 32'hFFFF_FFF6);
        chk("imm_op", 32'(alu_op_o), 32'(ALU_SUB));

        // backpressure: 3 stalled cycles with a pending new request
        issue(5'd5, 5'd2, 0, '0, ALU_XOR, 5'd8);
        cyc();
        held_a = a_o;
        out_ready_i = 0;
        issue(5'd9, 5'd9, 0, '0, ALU_AND, 5'd9);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_ready", 32'(in_ready_o), 32'd0);
            chk("stall_a", a_o, held_a);
        end

        // async reset pulse between edges while holding an entry
        #2 rst_ni = 0;
        #1;
        chk("arst_valid", 32'(out_valid_o), 32'd0);
        m_reset();
        @(negedge clk_i);
        rst_ni = 1;
        idle();
        cyc();
        chk("arst_no_emit", 32'(out_valid_o), 32'd0);
        issue(5'd5, 5'd9, 0, '0, ALU_ADD, 5'd1);
        cyc();
        chk("arst_r5", a_o, 32'd0);

        // back-to-back traffic, one per cycle
        for (int i = 1; i <= 8; i++) begin
            we_i = 1; wa_i = 5'(i + 10); wd_i = 32'(i * 32'h0101_0101);
            issue(5'(i + 9), 5'(i + 10), 0, '0, 4'(i), 5'(i));
            cyc();
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            we_i        = 1'($urandom_range(0, 1));
            wa_i        = 5'($urandom_range(0, 7));
            wd_i        = $urandom;
            ra1_i       = 5'($urandom_range(0, 7));
            ra2_i       = 5'($urandom_range(0, 7));
            use_imm_i   = 1'($urandom_range(0, 1));
            imm_i       = $urandom;
            alu_op_i    = 4'($urandom);
            rd_i        = 5'($urandom);
            cyc();
        end

        idle();
        repeat (2) cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
